vga_sync_gen: RTL

- Raster timing generator that drives the VGA peripheral's pixel/VRAM scan stage.
- Produces the current beam position (x, y), sync pulses, a blank flag, a per-line new-scanline strobe, and a sticky start-of-vertical-blank interrupt that the CPU clears.
- Sits directly upstream of the VRAM scan-out logic inside the TinyQV VGA peripheral.
- Default timing is 1024x768@60, run from the 64 MHz project clock.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 33 +++
 rtl/vga_sync_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA sync generator.
// Defaults describe 1024x768@60 driven from a 64 MHz pixel clock.
package vga_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_H_VISIBLE = 1024;
    localparam int DEF_H_FRONT   = 24;
    localparam int DEF_H_SYNC    = 136;
    localparam int DEF_H_BACK    = 160;

    localparam int DEF_V_VISIBLE = 768;
    localparam int DEF_V_FRONT   = 3;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 29;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter for one raster axis.
// Counts 0..TOTAL-1 while enabled; wrap flags the edge on which it returns to 0.
module vga_axis_counter #(
    parameter int W     = 11,
    parameter int TOTAL = 1344
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    if (TOTAL < 2 || TOTAL > (1 << W)) begin : g_bad_total
        $error("vga_axis_counter: TOTAL=%0d does not fit a %0d-bit counter", TOTAL, W);
    end

    assign wrap = en && (count == LAST);

    // NOTE: non-blocking so the vertical counter samples the pre-edge horizontal wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: beam position, sync pulses, blank, new-line strobe
// and a sticky start-of-vertical-blank interrupt cleared by the CPU.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE     = DEF_H_VISIBLE,
    parameter int   H_FRONT       = DEF_H_FRONT,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BACK        = DEF_H_BACK,
    parameter int   V_VISIBLE     = DEF_V_VISIBLE,
    parameter int   V_FRONT       = DEF_V_FRONT,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BACK        = DEF_V_BACK,
    parameter logic H_SYNC_ACTIVE = 1'b0,
    parameter logic V_SYNC_ACTIVE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cli,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           retrace,
    output logic           interrupt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed the %0d/%0d-bit position widths",
               H_TOTAL, V_TOTAL, X_W, Y_W);
    end

    // One extra bit on window limits so an end equal to 2**W does not truncate to 0.
    localparam logic [X_W:0]   H_VIS_END   = (X_W+1)'(H_VISIBLE);
    localparam logic [X_W:0]   H_SYNC_BEG  = (X_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [X_W:0]   H_SYNC_END  = (X_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W:0]   V_VIS_END   = (Y_W+1)'(V_VISIBLE);
    localparam logic [Y_W:0]   V_SYNC_BEG  = (Y_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W:0]   V_SYNC_END  = (Y_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [Y_W-1:0] V_LAST_VIS  = Y_W'(V_VISIBLE - 1);

    logic           h_wrap;
    logic           v_wrap;
    logic [X_W:0]   x_ext;
    logic [Y_W:0]   y_ext;
    logic           in_hsync;
    logic           in_vsync;
    logic           vblank_start;

    vga_axis_counter #(
        .W     (X_W),
        .TOTAL (H_TOTAL)
    ) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (x),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .W     (Y_W),
        .TOTAL (V_TOTAL)
    ) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (y),
        .wrap  (v_wrap)
    );

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};

    assign in_hsync = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
    assign in_vsync = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);

    assign hsync   = in_hsync ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
    assign vsync   = in_vsync ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
    assign blank   = (x_ext >= H_VIS_END) || (y_ext >= V_VIS_END);
    assign retrace = (x_ext == H_VIS_END);

    // The edge that moves the beam from the last visible line into vertical blank.
    assign vblank_start = h_wrap && (y == V_LAST_VIS);

    // Set has priority so a frame event coinciding with a clear is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interrupt <= 1'b0;
        end else if (vblank_start) begin
            interrupt <= 1'b1;
        end else if (cli) begin
            interrupt <= 1'b0;
        end
    end

endmodule
